pipeline_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage ARM core. Replaces the tied-off flush/freeze nets.

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/mem_wait_fsm.sv | 57 +++++
 rtl/pipeline_ctrl.sv | 69 ++++++
 tb/tb_pipeline_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline controller: memory-wait FSM
// encodings, default parameters and the RAW operand-match helper.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_st_e;

    localparam int MEM_WAIT_DEF = 4;
    localparam int CNT_W_DEF    = 16;

    // True when the ID instruction really reads register d.
    function automatic logic id_reads(
        input logic       src1_vld,
        input logic [3:0] src1,
        input logic       two_src,
        input logic [3:0] src2,
        input logic [3:0] d
    );
        return (src1_vld && (src1 == d)) || (two_src && (src2 == d));
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Multi-cycle data-memory wait sequencer: freezes the pipe for MEM_WAIT
// cycles per access, then releases for one retire cycle.
module mem_wait_fsm
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    output logic mem_freeze,
    output logic mem_busy
);

    localparam logic [3:0] LP_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

    mem_st_e    r_state, w_nxt_state;
    logic [3:0] r_cnt, w_nxt_cnt;
    logic       w_freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_freeze    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req && (MEM_WAIT > 0)) begin
                    w_freeze    = 1'b1;
                    w_nxt_cnt   = LP_LOAD;
                    w_nxt_state = (MEM_WAIT == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_freeze  = 1'b1;
                w_nxt_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_nxt_state = ST_DONE;
            end
            // Retire cycle: mem_req still names the finishing access, so ignore it.
            ST_DONE: w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign mem_freeze = w_freeze & ~rst;
    assign mem_busy   = (r_state != ST_IDLE) & ~rst;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: RAW stall, branch flush and memory freeze
// generation with saturating stall/flush statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_src1_vld,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             branch_taken,
    output logic             hazard_freeze,
    output logic             flush,
    output logic             mem_freeze,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic w_exe_hit, w_mem_hit, w_raw_hz, w_mem_freeze;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    mem_wait_fsm #(.MEM_WAIT(MEM_WAIT)) u_mem_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_freeze (w_mem_freeze),
        .mem_busy   (mem_busy)
    );

    assign w_exe_hit = exe_wb_en & id_reads(id_src1_vld, id_src1, id_two_src, id_src2, exe_dest);
    assign w_mem_hit = mem_wb_en & id_reads(id_src1_vld, id_src1, id_two_src, id_src2, mem_dest);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_raw_hz = forward_en ? (w_exe_hit & exe_mem_r_en) : (w_exe_hit | w_mem_hit);

    assign mem_freeze    = w_mem_freeze;
    assign flush         = branch_taken & ~w_mem_freeze & ~rst;
    assign hazard_freeze = w_raw_hz & ~branch_taken & ~w_mem_freeze & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((hazard_freeze | mem_freeze) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + LP_ONE;
            if (flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + LP_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl, two configurations
// (MEM_WAIT=4/CNT_W=4 and MEM_WAIT=1/CNT_W=16) against an access-age model.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst, forward_en, id_two_src, id_src1_vld;
    logic exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, branch_taken;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

    logic hz0, fl0, mf0, bz0, hz1, fl1, mf1, bz1;
    logic [3:0]  scnt0, fcnt0;
    logic [15:0] scnt1, fcnt1;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_WAIT(4), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_src1_vld(id_src1_vld),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
        .hazard_freeze(hz0), .flush(fl0), .mem_freeze(mf0), .mem_busy(bz0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    pipeline_ctrl #(.MEM_WAIT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_src1_vld(id_src1_vld),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .branch_taken(branch_taken),
        .hazard_freeze(hz1), .flush(fl1), .mem_freeze(mf1), .mem_busy(bz1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    // Model: age = cycles since the current access entered MEM (-1 = none).
    int mw[2]     = '{4, 1};
    int cmax[2]   = '{15, 65535};
    int age[2]    = '{-1, -1};
    int m_scnt[2] = '{0, 0};
    int m_fcnt[2] = '{0, 0};
    int e_n[2];
    bit m_hz[2], m_mf[2], m_fl[2];

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [3:0] d);
        return (id_src1_vld && id_src1 == d) || (id_two_src && id_src2 == d);
    endfunction

    task automatic step();
        bit raw, st, bz;
        @(negedge clk);
        if (forward_en) raw = exe_mem_r_en && exe_wb_en && reads(exe_dest);
        else            raw = (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
        for (int k = 0; k < 2; k++) begin
            st      = !rst && age[k] < 0 && mem_req && mw[k] > 0;
            e_n[k]  = st ? 0 : age[k];
            m_mf[k] = !rst && e_n[k] >= 0 && e_n[k] < mw[k];
            bz      = !rst && age[k] >= 0;
            m_fl[k] = !rst && branch_taken && !m_mf[k];
            m_hz[k] = !rst && raw && !branch_taken && !m_mf[k];
            if (k == 0) begin
                chk("hz0", int'(hz0), int'(m_hz[0]));
                chk("fl0", int'(fl0), int'(m_fl[0]));
                chk("mf0", int'(mf0), int'(m_mf[0]));
                chk("bz0", int'(bz0), int'(bz));
                chk("scnt0", int'(scnt0), m_scnt[0]);
                chk("fcnt0", int'(fcnt0), m_fcnt[0]);
            end else begin
                chk("hz1", int'(hz1), int'(m_hz[1]));
                chk("fl1", int'(fl1), int'(m_fl[1]));
                chk("mf1", int'(mf1), int'(m_mf[1]));
                chk("bz1", int'(bz1), int'(bz));
                chk("scnt1", int'(scnt1), m_scnt[1]);
                chk("fcnt1", int'(fcnt1), m_fcnt[1]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                age[k] = -1; m_scnt[k] = 0; m_fcnt[k] = 0;
            end else begin
                if (e_n[k] >= 0) begin
                    e_n[k]++;
                    if (e_n[k] > mw[k]) e_n[k] = -1;
                end
                age[k] = e_n[k];
                if ((m_hz[k] || m_mf[k]) && m_scnt[k] < cmax[k]) m_scnt[k]++;
                if (m_fl[k] && m_fcnt[k] < cmax[k]) m_fcnt[k]++;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        forward_en = 1'b1; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_src1_vld = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_scnt", int'(scnt0), 0);

        // Load-use with forwarding: EXE LDR r1, ID ADD r2,r1,r3
        exe_dest = 4'd1; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        id_src1 = 4'd1; id_src1_vld = 1'b1; id_src2 = 4'd3; id_two_src = 1'b1;
        step();
        chk("lu_hz", int'(m_hz[0]), 1);
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        step();
        chk("lu_cnt", int'(scnt0), 1);

        // No forwarding: MEM writes r4, ID reads r4 via src2
        forward_en = 1'b0; mem_dest = 4'd4; mem_wb_en = 1'b1;
        id_src1 = 4'd7; id_src2 = 4'd4; id_two_src = 1'b1;
        step();
        id_two_src = 1'b0;
        step();

        // Branch with RAW pending: flush wins
        id_two_src = 1'b1; branch_taken = 1'b1;
        step();
        branch_taken = 1'b0; mem_wb_en = 1'b0; id_two_src = 1'b0;
        do_reset();

        // One access, exact freeze/busy pattern; branch held across it
        mem_req = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("acc_mf", int'(m_mf[0]), (i < 4) ? 1 : 0);
            chk("acc_fl", int'(m_fl[0]), (i == 4) ? 1 : 0);
            if (i == 3) mem_req = 1'b0;
        end
        branch_taken = 1'b0;
        step();
        chk("acc_fcnt", int'(fcnt0), 1);

        // Reset in the middle of WAIT
        mem_req = 1'b1;
        step(); step();
        mem_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_busy", int'(bz0), 0);

        // Saturation of the 4-bit stall counter
        forward_en = 1'b0; exe_dest = 4'd2; exe_wb_en = 1'b1; id_src1 = 4'd2; id_src1_vld = 1'b1;
        repeat (20) step();
        chk("sat_scnt", int'(scnt0), 15);
        idle_inputs();
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            forward_en   = 1'($urandom);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom);
            id_src1_vld  = 1'($urandom);
            exe_dest     = 4'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom);
            exe_mem_r_en = 1'($urandom);
            mem_dest     = 4'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom);
            mem_req      = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
